demod_segment_scheduler: RTL
============================

// Module: demod_segment_scheduler
// PURPOSE
//  Sequences one shared segment-decision unit across all NUM_SEG demodulation segments.
//  - Accepts one Q16.16 sample per segment over a valid/ready handshake.
//  - Resolves each sample against that segment's ref / ref_m pair.
//  - Collects the NUM_SEG results and reports completion with start/valid/busy.
//  Sits between the sample source and the modulation-pipe back end.
// PARAMETERS
//  NUM_SEG  10             number of segments per frame
//  DATA_W   32             sample/segment width, Q16.16 two's complement
//  REF_POS  32'h0001_0000  +1.0; ref[k] for even k, ref_m[k] for odd k
//  REF_NEG  32'hFFFF_0000  -1.0; ref[k] for odd k, ref_m[k] for even k
// PORTS
//  clk        in   1               system clock, rising edge
//  reset      in   1               asynchronous, active-high reset
//  start      in   1               begin a frame (sampled only in IDLE)
//  in_sample  in   DATA_W          input sample
//  in_valid   in   1               in_sample valid
//  in_ready   out  1               scheduler accepts in_sample this cycle
//  segments   out  NUM_SEG*DATA_W  packed results; segment k = bits [k*DATA_W +: DATA_W]
//  seg_idx    out  4               index of the segment the next accepted sample feeds
//  valid      out  1               one-cycle pulse: all segments of the frame are final
//  busy       out  1               frame in progress
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE; segments=0, seg_idx=0, in_ready=0, valid=0, busy=0.
//  FSM states: IDLE -> LOAD -> DRAIN -> DONE -> IDLE.
//  IDLE
//   - On start=1: clear segments to 0, seg_idx=0, go to LOAD.
//   - busy=1 from the next cycle.
//  LOAD
//   - in_ready=1.
//   - Accept = in_valid & in_ready; no accept means the cycle stalls with no state change.
//   - Each accepted sample is registered with its index (one-cycle delay stage).
//   - The next cycle writes segment[idx]:
//     - ($signed(sample) > 0) ? ref[idx] : ref_m[idx]
//     - sample==0 selects ref_m.
//     - 32'h8000_0000 is negative.
//   - seg_idx increments on each accept.
//   - On the NUM_SEG-th accept: go to DRAIN; seg_idx does not wrap past NUM_SEG-1 (holds).
//  DRAIN
//   - in_ready=0.
//   - The final pipelined write of segment[NUM_SEG-1] lands here.
//   - Go to DONE.
//  DONE
//   - valid=1 for exactly this cycle; busy=1.
//   - Go to IDLE; busy=0 and seg_idx=0 in IDLE.
//  Latency: start at cycle 0 with in_valid held high -> valid at cycle NUM_SEG+2 (12 by default).
//  Output hold: segments hold their values after valid until the next accepted start.
//  start while not in IDLE: ignored.
//  start in the same cycle as the DONE pulse: ignored; it must be reasserted in IDLE.
//  in_valid while in_ready=0: ignored; the sample is neither consumed nor buffered.
//  Reset mid-frame:
//   - Immediate return to IDLE with all outputs at reset values.
//   - A partial frame is discarded; no valid pulse.
//  Arithmetic: comparison only, no arithmetic; decision outputs are exact REF_POS/REF_NEG constants.
// STRUCTURE
//  Package demod_pkg:
//   - Q16_ONE, Q16_MINUS_ONE, NUM_SEG.
//   - State encoding typedef (IDLE/LOAD/DRAIN/DONE).
//   - Function ref_of(k) and ref_m_of(k), returning the even/odd alternating references.
//  Sub-module seg_decide:
//   - Registered compare-and-select: sample, ref, ref_m in; decision out; one-cycle latency.
//   - The scheduler instantiates it once and time-shares it across all segments.
//  The scheduler owns the FSM, index counter, segment register file and handshake.
// TESTING
//  1. Reset, then start with samples +0.5,-0.5 alternating, in_valid always high
//     -> segments alternate 0x00010000 for every k (even k gets ref=+1, odd k gets ref_m=+1).
//     -> valid pulses once at cycle 12; busy=1 from cycles 1..12.
//  2. All samples 0x00000000
//     -> even k = 0xFFFF0000, odd k = 0x00010000 (ref_m path); 32'h80000000 also takes ref_m.
//  3. in_valid low for 3 cycles between samples 4 and 5
//     -> seg_idx holds at 5, in_ready stays 1, no segment corrupted, valid at cycle 15.
//  4. start pulsed during LOAD and in the DONE cycle
//     -> no restart; after IDLE, a fresh start clears segments to 0 before new writes.
//  5. reset asserted after 6 accepts
//     -> all outputs 0 asynchronously, no valid pulse; next frame completes normally.
//  6. Back-to-back frames with start held high
//     -> second frame begins the cycle after return to IDLE; each frame gets exactly one valid pulse.

Source files
------------

// File: rtl/demod_pkg.sv
// Shared constants, state encoding and reference helpers for the demodulation
// segment scheduler.
package demod_pkg;

  localparam int          NUM_SEG       = 10;
  localparam logic [31:0] Q16_ONE       = 32'h0001_0000;
  localparam logic [31:0] Q16_MINUS_ONE = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Even segments reference +pos, odd segments reference neg; ref_m is the mirror.
  function automatic logic [31:0] ref_of(input logic odd, input logic [31:0] pos,
                                         input logic [31:0] neg);
    return odd ? neg : pos;
  endfunction

  function automatic logic [31:0] ref_m_of(input logic odd, input logic [31:0] pos,
                                           input logic [31:0] neg);
    return odd ? pos : neg;
  endfunction

endpackage

// File: rtl/seg_decide.sv
// Registered compare-and-select: a strictly positive signed sample picks ref_in,
// zero or negative picks ref_m_in. One cycle of latency, updates only when enabled.
module seg_decide #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] ref_in,
  input  logic [DATA_W-1:0] ref_m_in,
  output logic [DATA_W-1:0] decision
);

  logic signed [DATA_W-1:0] sample_s;
  logic                     is_pos;
  logic [DATA_W-1:0]        decision_d;
  logic [DATA_W-1:0]        decision_q;

  assign sample_s = $signed(sample);

  always_comb begin
    // Sign bit clear and not all-zero: 0 and 0x8000_0000 both fall to ref_m.
    is_pos     = !sample_s[DATA_W-1] && (|sample_s);
    decision_d = decision_q;
    if (en) begin
      decision_d = is_pos ? ref_in : ref_m_in;
    end
  end

  // Stage boundary: decision register (datapath, no reset)
  always_ff @(posedge clk) begin
    decision_q <= decision_d;
  end

  assign decision = decision_q;

endmodule

// File: rtl/demod_segment_scheduler.sv
// Time-shares one seg_decide unit across NUM_SEG segments: loads one sample per
// segment over valid/ready, writes each decision one cycle later, pulses valid.
module demod_segment_scheduler #(
  parameter int          NUM_SEG = demod_pkg::NUM_SEG,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] REF_POS = demod_pkg::Q16_ONE,
  parameter logic [31:0] REF_NEG = demod_pkg::Q16_MINUS_ONE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_W-1:0]         in_sample,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_SEG*DATA_W-1:0] segments,
  output logic [3:0]                seg_idx,
  output logic                      valid,
  output logic                      busy
);

  import demod_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_SEG - 1);

  sched_state_e              state_q, state_d;
  logic [3:0]                seg_idx_q, seg_idx_d;
  logic                      wr_vld_q, wr_vld_d;
  logic [3:0]                wr_idx_q, wr_idx_d;
  logic [NUM_SEG*DATA_W-1:0] segments_q, segments_d;
  logic                      accept;
  logic                      clear_segs;
  logic [DATA_W-1:0]         ref_sel;
  logic [DATA_W-1:0]         ref_m_sel;
  logic [DATA_W-1:0]         decision;

  assign accept    = in_valid && (state_q == ST_LOAD);
  assign ref_sel   = ref_of(seg_idx_q[0], REF_POS, REF_NEG);
  assign ref_m_sel = ref_m_of(seg_idx_q[0], REF_POS, REF_NEG);

  seg_decide #(
    .DATA_W (DATA_W)
  ) u_seg_decide (
    .clk      (clk),
    .en       (accept),
    .sample   (in_sample),
    .ref_in   (ref_sel),
    .ref_m_in (ref_m_sel),
    .decision (decision)
  );

  always_comb begin
    state_d    = state_q;
    seg_idx_d  = seg_idx_q;
    wr_vld_d   = 1'b0;
    wr_idx_d   = wr_idx_q;
    clear_segs = 1'b0;
    case (state_q)
      ST_IDLE: begin
        seg_idx_d = '0;
        if (start) begin
          clear_segs = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_vld_d = 1'b1;
          wr_idx_d = seg_idx_q;
          // The last index holds so seg_idx never points past the frame.
          if (seg_idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            seg_idx_d = seg_idx_q + 4'd1;
          end
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        state_d   = ST_IDLE;
        seg_idx_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    segments_d = segments_q;
    if (clear_segs) begin
      segments_d = '0;
    end
    for (int k = 0; k < NUM_SEG; k++) begin
      if (wr_vld_q && (wr_idx_q == 4'(k))) begin
        segments_d[k*DATA_W +: DATA_W] = decision;
      end
    end
  end

  // Stage boundary: control state plus the index that travels with the decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      seg_idx_q <= '0;
      wr_vld_q  <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      seg_idx_q <= seg_idx_d;
      wr_vld_q  <= wr_vld_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  // Stage boundary: segment register file, cleared by reset since it is a visible output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      segments_q <= '0;
    end else begin
      segments_q <= segments_d;
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign valid    = (state_q == ST_DONE);
  assign seg_idx  = seg_idx_q;
  assign segments = segments_q;

endmodule
